// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking, leading-zero
// suppression and tear-free value updates at frame boundaries.

module DecoderBinTo7SegHex (
  input  logic [3:0] i_bin,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = '0;
    unique case (i_bin)
      4'h0: o_seg = 7'b1111110;
      4'h1: o_seg = 7'b0110000;
      4'h2: o_seg = 7'b1101101;
      4'h3: o_seg = 7'b1111001;
      4'h4: o_seg = 7'b0110011;
      4'h5: o_seg = 7'b1011011;
      4'h6: o_seg = 7'b1011111;
      4'h7: o_seg = 7'b1110000;
      4'h8: o_seg = 7'b1111111;
      4'h9: o_seg = 7'b1111011;
      4'hA: o_seg = 7'b1110111;
      4'hB: o_seg = 7'b0011111;
      4'hC: o_seg = 7'b1001110;
      4'hD: o_seg = 7'b0111101;
      4'hE: o_seg = 7'b1001111;
      4'hF: o_seg = 7'b1000111;
    endcase
  end
endmodule

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      enable,
  input  logic                      lzBlankIn,
  input  logic                      loadIn,
  input  logic [4*NUM_DIGITS-1:0]   valueIn,
  input  logic [NUM_DIGITS-1:0]     dpIn,
  output logic [7:0]                segOut,
  output logic [NUM_DIGITS-1:0]     digitEn,
  output logic                      pendingOut,
  output logic                      frameDone
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_slot, w_slot_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_act_val, w_act_val_nxt, r_shd_val;
  logic [NUM_DIGITS-1:0]   r_act_dp, w_act_dp_nxt, r_shd_dp;
  logic                    w_pend_nxt, w_frame_end, w_commit, w_drive;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_nib;
  logic                    w_dp, w_lz_sel;
  logic [6:0]              w_dec;
  logic [7:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_en_nxt;

  // Outputs are registered but computed from next-cycle counters and next
  // active value, so what appears each cycle belongs to the current slot.
  always_comb begin
    w_state_nxt = enable ? ST_SCAN : ST_IDLE;
    w_slot_nxt  = '0;
    w_idx_nxt   = '0;
    w_frame_end = 1'b0;
    if (enable && r_state == ST_SCAN) begin
      if (r_slot == LAST_SLOT) begin
        if (r_idx == LAST_IDX) w_frame_end = 1'b1;
        else                   w_idx_nxt   = r_idx + 1'b1;
      end else begin
        w_slot_nxt = r_slot + 1'b1;
        w_idx_nxt  = r_idx;
      end
    end

    w_commit      = (r_state == ST_IDLE) || w_frame_end;
    w_act_val_nxt = r_act_val;
    w_act_dp_nxt  = r_act_dp;
    w_pend_nxt    = pendingOut;
    if (loadIn && w_commit) begin
      w_act_val_nxt = valueIn;
      w_act_dp_nxt  = dpIn;
      w_pend_nxt    = 1'b0;
    end else if (loadIn) begin
      w_pend_nxt    = 1'b1;
    end else if (w_commit && pendingOut) begin
      w_act_val_nxt = r_shd_val;
      w_act_dp_nxt  = r_shd_dp;
      w_pend_nxt    = 1'b0;
    end
  end

  // Digit i is blanked when every nibble from the top down to i is zero.
  always_comb begin
    logic w_zrun;
    w_zrun = 1'b1;
    w_lz   = '0;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zrun  = w_zrun && (w_act_val_nxt[4*i +: 4] == 4'h0);
      w_lz[i] = w_zrun;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_dp     = 1'b0;
    w_lz_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IW'(i)) begin
        w_nib    = w_act_val_nxt[4*i +: 4];
        w_dp     = w_act_dp_nxt[i];
        w_lz_sel = w_lz[i];
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign w_drive = 1'b1;
    end else begin : g_blank
      assign w_drive = (w_slot_nxt >= CW'(BLANK_CYCLES));
    end
  endgenerate

  DecoderBinTo7SegHex u_dec (
    .i_bin (w_nib),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg_nxt = '0;
    w_en_nxt  = '0;
    if (w_state_nxt == ST_SCAN && w_drive) begin
      w_en_nxt  = NUM_DIGITS'(1) << w_idx_nxt;
      w_seg_nxt = {w_dp, (lzBlankIn && w_lz_sel) ? 7'b0 : w_dec};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_idx      <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_shd_val  <= '0;
      r_shd_dp   <= '0;
      pendingOut <= 1'b0;
      segOut     <= '0;
      digitEn    <= '0;
      frameDone  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_idx      <= w_idx_nxt;
      r_act_val  <= w_act_val_nxt;
      r_act_dp   <= w_act_dp_nxt;
      if (loadIn) begin
        r_shd_val <= valueIn;
        r_shd_dp  <= dpIn;
      end
      pendingOut <= w_pend_nxt;
      segOut     <= w_seg_nxt;
      digitEn    <= w_en_nxt;
      frameDone  <= w_frame_end;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: driver updates a frame-time reference model and queues
// expected outputs; a monitor compares them one time unit after each edge.

module tb_seven_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FL = N * TD;

  logic        clk = 1'b0;
  logic        rstN = 1'b0, enable = 1'b0, lzB = 1'b0, ld = 1'b0;
  logic [15:0] val = '0;
  logic [3:0]  dp = '0;
  logic [7:0]  segOut;
  logic [3:0]  digitEn;
  logic        pendingOut, frameDone;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .lzBlankIn(lzB), .loadIn(ld),
    .valueIn(val), .dpIn(dp), .segOut(segOut), .digitEn(digitEn),
    .pendingOut(pendingOut), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] en;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] DEC [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: elapsed time since scan start plus active/shadow words.
  bit          m_run = 0;
  int          m_t   = 0;
  logic [15:0] m_act = '0, m_shd = '0;
  logic [3:0]  m_adp = '0, m_sdp = '0;
  bit          m_pend = 0;
  logic        cur_lz = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("segOut",     segOut,               e.seg);
      check("digitEn",    {4'b0, digitEn},      {4'b0, e.en});
      check("pendingOut", {7'b0, pendingOut},   {7'b0, e.pend});
      check("frameDone",  {7'b0, frameDone},    {7'b0, e.fd});
    end
  end

  task automatic step(input logic r, input logic e, input logic l, input logic L,
                      input logic [15:0] v, input logic [3:0] d);
    exp_t ex;
    bit   bound, commit;
    int   slot, dig;
    logic [3:0] nib;
    @(negedge clk);
    rstN = r; enable = e; ld = l; lzB = L; val = v; dp = d;
    @(posedge clk);
    ex = '0;
    if (!r) begin
      m_run = 0; m_t = 0; m_act = '0; m_shd = '0; m_adp = '0; m_sdp = '0; m_pend = 0;
    end else begin
      bound  = m_run && e && ((m_t % FL) == FL - 1);
      commit = !m_run || bound;
      if (l) begin
        m_shd = v; m_sdp = d;
        if (commit) begin m_act = v; m_adp = d; m_pend = 0; end
        else m_pend = 1;
      end else if (commit && m_pend) begin
        m_act = m_shd; m_adp = m_sdp; m_pend = 0;
      end
      if (!e)          begin m_run = 0; m_t = 0; end
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t++;
      ex.fd   = bound;
      ex.pend = m_pend;
      if (m_run) begin
        slot = m_t % TD;
        dig  = (m_t / TD) % N;
        if (slot >= BC) begin
          ex.en  = 4'(1 << dig);
          nib    = 4'(m_act >> (4 * dig));
          ex.seg = {m_adp[dig],
                    (L && dig > 0 && (m_act >> (4 * dig)) == 0) ? 7'b0 : DEC[nib]};
        end
      end
    end
    q.push_back(ex);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, cur_lz, '0, '0);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    step(1'b1, 1'b1, 1'b1, cur_lz, v, d);
  endtask

  task automatic load_on_boundary(input logic [15:0] v, input logic [3:0] d);
    int k;
    k = 0;
    while (!(m_run && (m_t % FL) == FL - 1) && k < 2 * FL) begin
      run(1);
      k++;
    end
    load(v, d);
  endtask

  initial begin
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    run(3 * FL);

    load(16'h7654, 4'b0100); run(2 * FL);
    load(16'hFEDC, 4'b1010); run(2 * FL);
    load(16'hBA98, 4'b0001); run(2 * FL);
    load(16'h1234, 4'b0000); run(2 * FL);
    run(TD + BC + 1);
    load(16'hABCD, 4'b1000); run(2 * FL);

    load_on_boundary(16'h5A3C, 4'b0110); run(FL + 4);
    load(16'h1111, 4'b0000); load_on_boundary(16'h2222, 4'b0011); run(FL);

    cur_lz = 1'b1;
    load_on_boundary(16'h0030, 4'b0000); run(2 * FL);
    load_on_boundary(16'h0000, 4'b0100); run(2 * FL);
    load_on_boundary(16'h0102, 4'b0000); run(FL);
    cur_lz = 1'b0;

    run(2 * TD + 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 4'b1001);
    run(FL + 5);
    load(16'h9876, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    run(FL);
    run(TD + BC + 2);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    run(FL);

    for (int i = 0; i < 2500; i++) begin
      logic r, e, l;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 79) != 0);
      l = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 63) == 0) cur_lz = ~cur_lz;
      step(r, e, l, cur_lz, 16'($urandom), 4'($urandom));
    end
    run(4);

    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
